// File: rtl/elastic_register.sv
// elastic_register: valid/ready pipeline register with a one-entry skid buffer.
// Every output comes straight from a flop, so no combinational path crosses the stage
// in either direction.
// Optional feature macro: ELASTIC_REG_PERF_EN enables a saturating stall-cycle counter
// on stall_cnt_o. When it is undefined, stall_cnt_o is tied to zero.
module elastic_register #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [1:0]           occupancy_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OCC_W-1:0]   occupancy_q, occupancy_d;
  logic               in_fire;
  logic               out_fire;

  // Handshake events, both taken from registered outputs.
  always_comb begin
    in_fire  = in_valid_i & in_ready_q;
    out_fire = out_valid_q & out_ready_i;
  end

  // Next state and slot contents; a flush overrides the handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = ONE;
          main_data_d = in_data_i;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data_i;
        end else if (in_fire) begin
          state_d     = FULL;
          skid_data_d = in_data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush_i) begin
      state_d     = EMPTY;
      main_data_d = '0;
      skid_data_d = '0;
    end
  end

  // Registered status outputs are derived from the next state.
  always_comb begin
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    occupancy_d = OCC_W'(out_valid_d) + OCC_W'(state_d == FULL);
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_data_q;
  assign occupancy_o = occupancy_q;

`ifdef ELASTIC_REG_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where the stage holds a beat but downstream refuses it. The counter
  // saturates instead of wrapping, and it holds its value across a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!flush_i && out_valid_q && !out_ready_i && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_elastic_register.sv
// Directed testbench for elastic_register. The expected values below are worked out
// by hand, and the stall count is tracked by a small saturating model in the bench.
module tb_elastic_register;

  localparam int unsigned WIDTH     = 64;
  localparam int unsigned CNT_WIDTH = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 flush_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [WIDTH-1:0]     in_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [WIDTH-1:0]     out_data_o;
  logic [1:0]           occupancy_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [CNT_WIDTH-1:0] exp_stall = '0;

  elastic_register #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Wait for one rising edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected-model update for one stall edge. It stays at 0 when the counter is compiled out.
  task automatic bump_stall();
`ifdef ELASTIC_REG_PERF_EN
    if (exp_stall != {CNT_WIDTH{1'b1}}) exp_stall = exp_stall + CNT_WIDTH'(1);
`endif
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1; in_data_i = 64'h55; out_ready_i = 1'b0;
    tick();
    tick();
    exp_stall = '0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid_o); end
    checks++; if (out_data_o !== 64'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", out_data_o); end
    checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy_o); end
    checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL reset_stall got %0d exp %0d", stall_cnt_o, exp_stall); end
    rst_i = 1'b0; in_valid_i = 1'b0;
    tick();
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_no_beat got %0b exp 0", out_valid_o); end
  endtask

  task automatic test_streaming();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1; in_data_i = 64'(i);
      tick();
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'(i)) begin
        errors++; $display("FAIL stream_out%0d got v=%0b d=%0h exp v=1 d=%0h", i, out_valid_o, out_data_o, i);
      end
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %0b exp 1", i, in_ready_o); end
    end
    in_valid_i = 1'b0;
    tick();
    checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      errors++; $display("FAIL stream_drain got v=%0b occ=%0d exp v=0 occ=0", out_valid_o, occupancy_o);
    end
  endtask

  task automatic test_back_pressure();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 64'hA;
    tick();
    checks++; if (occupancy_o !== 2'd1 || in_ready_o !== 1'b1 || out_data_o !== 64'hA) begin
      errors++; $display("FAIL bp_one got occ=%0d rdy=%0b d=%0h exp occ=1 rdy=1 d=a", occupancy_o, in_ready_o, out_data_o);
    end
    in_data_i = 64'hB;
    tick(); bump_stall();
    checks++; if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== 64'hA) begin
      errors++; $display("FAIL bp_full got occ=%0d rdy=%0b d=%0h exp occ=2 rdy=0 d=a", occupancy_o, in_ready_o, out_data_o);
    end
    // A beat offered while the stage is full must be ignored.
    in_data_i = 64'hDD;
    tick(); bump_stall();
    checks++; if (occupancy_o !== 2'd2 || out_data_o !== 64'hA || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_hold got occ=%0d v=%0b d=%0h exp occ=2 v=1 d=a", occupancy_o, out_valid_o, out_data_o);
    end
    checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL bp_stall got %0d exp %0d", stall_cnt_o, exp_stall); end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hB || in_ready_o !== 1'b1 || occupancy_o !== 2'd1) begin
      errors++; $display("FAIL bp_drain1 got v=%0b d=%0h rdy=%0b occ=%0d exp v=1 d=b rdy=1 occ=1", out_valid_o, out_data_o, in_ready_o, occupancy_o);
    end
    tick();
    checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      errors++; $display("FAIL bp_drain2 got v=%0b occ=%0d exp v=0 occ=0", out_valid_o, occupancy_o);
    end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 64'h11;
    tick();
    in_data_i = 64'h22;
    tick(); bump_stall();
    checks++; if (occupancy_o !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d exp 2", occupancy_o); end
    in_data_i = 64'hC; flush_i = 1'b1;
    tick();
    checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || in_ready_o !== 1'b1 || out_data_o !== 64'h0) begin
      errors++; $display("FAIL flush_clear got v=%0b occ=%0d rdy=%0b d=%0h exp v=0 occ=0 rdy=1 d=0", out_valid_o, occupancy_o, in_ready_o, out_data_o);
    end
    checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL flush_stall_hold got %0d exp %0d", stall_cnt_o, exp_stall); end
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_c%0d got v=%0b d=%0h exp v=0", i, out_valid_o, out_data_o); end
    end
    in_valid_i = 1'b1; in_data_i = 64'h33;
    tick();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'h33) begin
      errors++; $display("FAIL flush_recover got v=%0b d=%0h exp v=1 d=33", out_valid_o, out_data_o);
    end
    in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 64'h44;
    tick();
    in_data_i = 64'h55;
    tick(); bump_stall();
    checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL mrst_pre_stall got %0d exp %0d", stall_cnt_o, exp_stall); end
    in_valid_i = 1'b0; rst_i = 1'b1;
    tick();
    exp_stall = '0;
    checks++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || in_ready_o !== 1'b1 || out_data_o !== 64'h0) begin
      errors++; $display("FAIL mrst_clear got v=%0b occ=%0d rdy=%0b d=%0h exp v=0 occ=0 rdy=1 d=0", out_valid_o, occupancy_o, in_ready_o, out_data_o);
    end
    checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL mrst_stall got %0d exp 0", stall_cnt_o); end
    rst_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_stale%0d got v=%0b d=%0h exp v=0", i, out_valid_o, out_data_o); end
    end
  endtask

  task automatic test_perf();
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 64'h66;
    tick();
    in_valid_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(); bump_stall();
      if (i == 10 || i == 15 || i == 20) begin
        checks++; if (stall_cnt_o !== exp_stall) begin
          errors++; $display("FAIL perf_stall%0d got %0d exp %0d", i, stall_cnt_o, exp_stall);
        end
      end
    end
    checks++; if (out_data_o !== 64'h66 || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL perf_hold got v=%0b d=%0h exp v=1 d=66", out_valid_o, out_data_o);
    end
    out_ready_i = 1'b1;
    tick();
    checks++; if (out_valid_o !== 1'b0 || stall_cnt_o !== exp_stall) begin
      errors++; $display("FAIL perf_drain got v=%0b cnt=%0d exp v=0 cnt=%0d", out_valid_o, stall_cnt_o, exp_stall);
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_mid_reset();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
